// File: rtl/picomips_pkg.sv
// picomips_pkg: shared handshake FSM state type and debounce default
package picomips_pkg;
  localparam int DB_CYCLES_DEFAULT = 16;
  typedef enum logic [1:0] {IDLE, RISE, HIGH, FALL} sw_state_t;
endpackage

// File: rtl/sw_conditioner_sync2.sv
// sync2: two-flop synchronizer, ports clk, reset (async active-low), d[W] in, q[W] out
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/sw_conditioner.sv
// sw_conditioner: sync/debounce board switches into CPU SW word; ports clk, reset(n), SW_raw in, SW/sw_valid/hs_count out
module sw_conditioner
  import picomips_pkg::*;
#(
  parameter int n         = 8,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n+1:0] SW_raw,
  output logic [n+1:0] SW,
  output logic         sw_valid,
  output logic [7:0]   hs_count
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  logic [n+1:0] s;
  logic hs, level, rise_done;
  logic [n-1:0] data;
  logic [CW-1:0] cnt, cnt_nx;
  sw_state_t state, state_nx;
  sync2 #(.W(n + 2)) u_sync (.clk(clk), .reset(reset), .d(SW_raw), .q(s));
  assign hs = s[n];
  assign rise_done = state == RISE && hs && cnt == LAST;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    unique case (state)
      IDLE: begin
        state_nx = hs ? RISE : IDLE;
        cnt_nx = '0;
      end
      RISE:
        if (!hs) state_nx = IDLE;
        else if (cnt == LAST) state_nx = HIGH;
        else cnt_nx = cnt + 1'b1;
      HIGH: begin
        state_nx = hs ? HIGH : FALL;
        cnt_nx = '0;
      end
      FALL:
        if (hs) state_nx = HIGH;
        else if (cnt == LAST) state_nx = IDLE;
        else cnt_nx = cnt + 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      level <= 1'b0;
      data <= '0;
      sw_valid <= 1'b0;
      hs_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      level <= state_nx == HIGH || state_nx == FALL;
      sw_valid <= rise_done;
      if (rise_done) begin
        data <= s[n-1:0];
        hs_count <= hs_count + 8'd1;
      end
    end
  assign SW = {s[n+1], level, data};
endmodule
